// File: rtl/wf68k30l_wr_dest_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : wf68k30l_wr_dest_seq_pkg
//  Description : Shared encodings for the destination write path: bus SIZ
//                codes, operand size codes, sequencer states and a helper
//                mapping byte counts onto SIZ codes.
//  Revision    : 1.0  initial release
// ============================================================================
package wf68k30l_wr_dest_seq_pkg;

    // 68k SIZ pin encodings
    localparam logic [1:0] SIZ_LONG  = 2'b00;
    localparam logic [1:0] SIZ_BYTE  = 2'b01;
    localparam logic [1:0] SIZ_WORD  = 2'b10;
    localparam logic [1:0] SIZ_3BYTE = 2'b11;

    // Operand size codes on WR_SIZE
    localparam logic [1:0] OPSZ_LONG = 2'b00;
    localparam logic [1:0] OPSZ_BYTE = 2'b01;
    localparam logic [1:0] OPSZ_WORD = 2'b10;

    // Sequencer states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CYC1 = 2'd1,
        CYC2 = 2'd2
    } wr_state_t;

    // Byte count (1..4) to SIZ code; 4 wraps to the long encoding
    function automatic logic [1:0] siz_enc(input logic [2:0] nbytes);
        logic [1:0] r;
        case (nbytes)
            3'd1:    r = SIZ_BYTE;
            3'd2:    r = SIZ_WORD;
            3'd3:    r = SIZ_3BYTE;
            default: r = SIZ_LONG;
        endcase
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/wf68k30l_wr_dest_seq_split.sv
`default_nettype none
// ============================================================================
//  Module      : wf68k30l_wr_split
//  Description : Combinational split calculator. From the address offset
//                within a longword and the operand size it derives whether
//                the access straddles a longword boundary, the byte counts
//                of both bus cycles, their SIZ codes and the data shift for
//                the first cycle.
//  Revision    : 1.0  initial release
// ============================================================================
module wf68k30l_wr_split
    import wf68k30l_wr_dest_seq_pkg::*;
(
    input  logic [1:0] off,
    input  logic [1:0] size,
    output logic       split,
    output logic [2:0] first,
    output logic [2:0] second,
    output logic [1:0] siz1,
    output logic [1:0] siz2,
    output logic [4:0] shift
);

    logic [2:0] w_n;
    logic [3:0] w_end;

    // Operand length, end position, and the split of bytes between cycles
    always_comb begin
        case (size)
            OPSZ_BYTE: w_n = 3'd1;
            OPSZ_WORD: w_n = 3'd2;
            default:   w_n = 3'd4;
        endcase
        w_end  = {2'b00, off} + {1'b0, w_n};
        split  = (w_end > 4'd4);
        first  = split ? (3'd4 - {1'b0, off}) : w_n;
        second = w_n - first;
        siz1   = siz_enc(first);
        siz2   = siz_enc(second);
        // Big-endian: the first cycle carries the upper bytes of the operand
        shift  = {second[1:0], 3'b000};
    end

endmodule
`default_nettype wire

// File: rtl/wf68k30l_wr_dest_seq.sv
`default_nettype none
// ============================================================================
//  Module      : wf68k30l_wr_dest_seq
//  Description : Destination write sequencer. Converts one operand write from
//                the execute FSM into one or two bus write cycles, splitting
//                at longword boundaries, carrying the RMW lock and reporting
//                bus errors.
//  Revision    : 1.0  initial release
// ============================================================================
module wf68k30l_wr_dest_seq
    import wf68k30l_wr_dest_seq_pkg::*;
#(
    parameter int ADR_W  = 32,
    parameter int DATA_W = 32
) (
    input  logic              CLK,
    input  logic              RESET_n,
    input  logic              WR_REQ,
    input  logic [ADR_W-1:0]  WR_ADR,
    input  logic [DATA_W-1:0] WR_DATA,
    input  logic [1:0]        WR_SIZE,
    input  logic [2:0]        WR_FC,
    input  logic              WR_RMC,
    input  logic              BUS_ACK,
    input  logic              BUS_ERR,
    output logic              BUS_WR_REQ,
    output logic [ADR_W-1:0]  BUS_ADR,
    output logic [DATA_W-1:0] BUS_DATA,
    output logic [1:0]        BUS_SIZE,
    output logic [2:0]        BUS_FC,
    output logic              BUS_RMC,
    output logic              WR_RDY,
    output logic              WR_BERR,
    output logic              WR_BUSY
);

    wr_state_t         r_state;
    wr_state_t         w_next;
    logic [ADR_W-1:0]  r_adr;
    logic [DATA_W-1:0] r_data;
    logic [1:0]        r_size;
    logic [2:0]        r_fc;
    logic              r_rmc;
    logic              r_berr;

    logic              w_split;
    logic [2:0]        w_first;
    logic [2:0]        w_second;
    logic [1:0]        w_siz1;
    logic [1:0]        w_siz2;
    logic [4:0]        w_shift;
    logic [DATA_W-1:0] w_mask;

    wf68k30l_wr_split u_split (
        .off    (r_adr[1:0]),
        .size   (r_size),
        .split  (w_split),
        .first  (w_first),
        .second (w_second),
        .siz1   (w_siz1),
        .siz2   (w_siz2),
        .shift  (w_shift)
    );

    assign w_mask = ~({DATA_W{1'b1}} << {w_second[1:0], 3'b000});

    // State register, request latch and registered bus-error pulse
    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            r_state <= IDLE;
            r_adr   <= '0;
            r_data  <= '0;
            r_size  <= '0;
            r_fc    <= '0;
            r_rmc   <= 1'b0;
            r_berr  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_berr  <= (r_state != IDLE) && BUS_ERR;
            if (r_state == IDLE && WR_REQ) begin
                r_adr  <= WR_ADR;
                r_data <= WR_DATA;
                r_size <= WR_SIZE;
                r_fc   <= WR_FC;
                r_rmc  <= WR_RMC;
            end
        end
    end

    // Next state and bus outputs; bus error wins over a simultaneous ACK
    always_comb begin
        w_next     = r_state;
        BUS_WR_REQ = 1'b0;
        BUS_ADR    = '0;
        BUS_DATA   = '0;
        BUS_SIZE   = 2'b00;
        BUS_FC     = 3'b000;
        BUS_RMC    = 1'b0;
        WR_RDY     = 1'b0;
        case (r_state)
            IDLE: begin
                if (WR_REQ) w_next = CYC1;
            end
            CYC1: begin
                BUS_WR_REQ = 1'b1;
                BUS_ADR    = r_adr;
                BUS_DATA   = r_data >> w_shift;
                BUS_SIZE   = w_siz1;
                BUS_FC     = r_fc;
                BUS_RMC    = r_rmc;
                if (BUS_ERR) begin
                    w_next = IDLE;
                end else if (BUS_ACK) begin
                    if (w_split) begin
                        w_next = CYC2;
                    end else begin
                        WR_RDY = 1'b1;
                        w_next = IDLE;
                    end
                end
            end
            CYC2: begin
                BUS_WR_REQ = 1'b1;
                BUS_ADR    = r_adr + ADR_W'(w_first);
                BUS_DATA   = r_data & w_mask;
                BUS_SIZE   = w_siz2;
                BUS_FC     = r_fc;
                BUS_RMC    = r_rmc;
                if (BUS_ERR) begin
                    w_next = IDLE;
                end else if (BUS_ACK) begin
                    WR_RDY = 1'b1;
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    assign WR_BERR = r_berr;
    assign WR_BUSY = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_wf68k30l_wr_dest_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_wf68k30l_wr_dest_seq
//  Description : Directed, table-driven bench for the destination write
//                sequencer plus hand-written error, reset and overlap cases.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_wf68k30l_wr_dest_seq;

    logic        CLK;
    logic        RESET_n;
    logic        WR_REQ;
    logic [31:0] WR_ADR;
    logic [31:0] WR_DATA;
    logic [1:0]  WR_SIZE;
    logic [2:0]  WR_FC;
    logic        WR_RMC;
    logic        BUS_ACK;
    logic        BUS_ERR;
    logic        BUS_WR_REQ;
    logic [31:0] BUS_ADR;
    logic [31:0] BUS_DATA;
    logic [1:0]  BUS_SIZE;
    logic [2:0]  BUS_FC;
    logic        BUS_RMC;
    logic        WR_RDY;
    logic        WR_BERR;
    logic        WR_BUSY;

    int checks   = 0;
    int failures = 0;
    int cur_vec  = -1;

    typedef struct {
        logic [31:0] adr;
        logic [31:0] data;
        logic [1:0]  size;
        logic [2:0]  fc;
        logic        rmc;
        int          waits;
        logic        split;
        logic [31:0] adr1;
        logic [1:0]  siz1;
        logic [31:0] data1;
        logic [31:0] adr2;
        logic [1:0]  siz2;
        logic [31:0] data2;
    } vec_t;

    vec_t vecs [8];

    wf68k30l_wr_dest_seq #(.ADR_W(32), .DATA_W(32)) dut (
        .CLK        (CLK),
        .RESET_n    (RESET_n),
        .WR_REQ     (WR_REQ),
        .WR_ADR     (WR_ADR),
        .WR_DATA    (WR_DATA),
        .WR_SIZE    (WR_SIZE),
        .WR_FC      (WR_FC),
        .WR_RMC     (WR_RMC),
        .BUS_ACK    (BUS_ACK),
        .BUS_ERR    (BUS_ERR),
        .BUS_WR_REQ (BUS_WR_REQ),
        .BUS_ADR    (BUS_ADR),
        .BUS_DATA   (BUS_DATA),
        .BUS_SIZE   (BUS_SIZE),
        .BUS_FC     (BUS_FC),
        .BUS_RMC    (BUS_RMC),
        .WR_RDY     (WR_RDY),
        .WR_BERR    (WR_BERR),
        .WR_BUSY    (WR_BUSY)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s (vec %0d): got 0x%08h expected 0x%08h", nm, cur_vec, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic issue(input logic [31:0] adr, input logic [31:0] data,
                         input logic [1:0] size, input logic [2:0] fc, input logic rmc);
        WR_ADR  = adr;
        WR_DATA = data;
        WR_SIZE = size;
        WR_FC   = fc;
        WR_RMC  = rmc;
        WR_REQ  = 1'b1;
        tick();
        WR_REQ  = 1'b0;
        #1;
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_bus_wr_req"}, {31'd0, BUS_WR_REQ}, 32'd0);
        chk({tag, "_busy"},       {31'd0, WR_BUSY},    32'd0);
        chk({tag, "_rmc"},        {31'd0, BUS_RMC},    32'd0);
        chk({tag, "_adr"},        BUS_ADR,             32'd0);
        chk({tag, "_data"},       BUS_DATA,            32'd0);
        chk({tag, "_rdy"},        {31'd0, WR_RDY},     32'd0);
    endtask

    task automatic run_vec(input vec_t v);
        issue(v.adr, v.data, v.size, v.fc, v.rmc);
        chk("c1_req",  {31'd0, BUS_WR_REQ}, 32'd1);
        chk("c1_busy", {31'd0, WR_BUSY},    32'd1);
        chk("c1_adr",  BUS_ADR,             v.adr1);
        chk("c1_siz",  {30'd0, BUS_SIZE},   {30'd0, v.siz1});
        chk("c1_data", BUS_DATA,            v.data1);
        chk("c1_fc",   {29'd0, BUS_FC},     {29'd0, v.fc});
        chk("c1_rmc",  {31'd0, BUS_RMC},    {31'd0, v.rmc});
        for (int w = 0; w < v.waits; w++) begin
            chk("c1_wait_rdy", {31'd0, WR_RDY}, 32'd0);
            tick();
            #1;
            chk("c1_wait_adr", BUS_ADR, v.adr1);
        end
        BUS_ACK = 1'b1;
        #1;
        chk("c1_ack_rdy", {31'd0, WR_RDY}, {31'd0, ~v.split});
        tick();
        BUS_ACK = 1'b0;
        #1;
        if (v.split) begin
            chk("c2_req",  {31'd0, BUS_WR_REQ}, 32'd1);
            chk("c2_adr",  BUS_ADR,             v.adr2);
            chk("c2_siz",  {30'd0, BUS_SIZE},   {30'd0, v.siz2});
            chk("c2_data", BUS_DATA,            v.data2);
            chk("c2_rmc",  {31'd0, BUS_RMC},    {31'd0, v.rmc});
            chk("c2_rdy0", {31'd0, WR_RDY},     32'd0);
            BUS_ACK = 1'b1;
            #1;
            chk("c2_ack_rdy", {31'd0, WR_RDY}, 32'd1);
            tick();
            BUS_ACK = 1'b0;
            #1;
        end
        check_idle("post");
    endtask

    initial begin
        RESET_n = 1'b0;
        WR_REQ  = 1'b0;
        WR_ADR  = '0;
        WR_DATA = '0;
        WR_SIZE = '0;
        WR_FC   = '0;
        WR_RMC  = 1'b0;
        BUS_ACK = 1'b0;
        BUS_ERR = 1'b0;

        //            adr           data          sz     fc    rmc w  sp  adr1          s1     data1         adr2          s2     data2
        vecs[0] = '{32'h0000_1000, 32'h1122_3344, 2'b00, 3'd5, 1'b0, 2, 1'b0, 32'h0000_1000, 2'b00, 32'h1122_3344, 32'h0,        2'b00, 32'h0};
        vecs[1] = '{32'h0000_1001, 32'hAABB_CCDD, 2'b00, 3'd1, 1'b0, 0, 1'b1, 32'h0000_1001, 2'b11, 32'h00AA_BBCC, 32'h0000_1004, 2'b01, 32'h0000_00DD};
        vecs[2] = '{32'h0000_2003, 32'h0000_BEEF, 2'b10, 3'd2, 1'b0, 1, 1'b1, 32'h0000_2003, 2'b01, 32'h0000_00BE, 32'h0000_2004, 2'b01, 32'h0000_00EF};
        vecs[3] = '{32'h0000_3002, 32'h1122_3344, 2'b00, 3'd5, 1'b1, 0, 1'b1, 32'h0000_3002, 2'b10, 32'h0000_1122, 32'h0000_3004, 2'b10, 32'h0000_3344};
        vecs[4] = '{32'h0000_4003, 32'h0000_005A, 2'b01, 3'd1, 1'b0, 0, 1'b0, 32'h0000_4003, 2'b01, 32'h0000_005A, 32'h0,        2'b00, 32'h0};
        vecs[5] = '{32'hFFFF_FFFE, 32'hCAFE_BABE, 2'b00, 3'd6, 1'b0, 1, 1'b1, 32'hFFFF_FFFE, 2'b10, 32'h0000_CAFE, 32'h0000_0000, 2'b10, 32'h0000_BABE};
        vecs[6] = '{32'h0000_5002, 32'h0000_1234, 2'b10, 3'd1, 1'b0, 0, 1'b0, 32'h0000_5002, 2'b10, 32'h0000_1234, 32'h0,        2'b00, 32'h0};
        vecs[7] = '{32'h0000_6001, 32'h0000_ABCD, 2'b10, 3'd2, 1'b1, 0, 1'b0, 32'h0000_6001, 2'b10, 32'h0000_ABCD, 32'h0,        2'b00, 32'h0};

        // Reset state
        #12;
        check_idle("reset");
        chk("reset_berr", {31'd0, WR_BERR}, 32'd0);
        #11 RESET_n = 1'b1;
        tick();

        // Table-driven transfers
        for (int i = 0; i < 8; i++) begin
            cur_vec = i;
            run_vec(vecs[i]);
            tick();
        end

        // Bus error on cycle 1 of a split write: no second cycle, no WR_RDY
        cur_vec = 100;
        issue(32'h0000_7001, 32'hDEAD_BEEF, 2'b00, 3'd5, 1'b1);
        chk("err_c1_siz", {30'd0, BUS_SIZE}, 32'd3);
        BUS_ERR = 1'b1;
        #1;
        chk("err_rdy", {31'd0, WR_RDY}, 32'd0);
        tick();
        BUS_ERR = 1'b0;
        #1;
        chk("err_berr_pulse", {31'd0, WR_BERR}, 32'd1);
        check_idle("err_idle");
        tick();
        #1;
        chk("err_berr_clear", {31'd0, WR_BERR}, 32'd0);
        chk("err_no_c2", {31'd0, BUS_WR_REQ}, 32'd0);

        // Simultaneous ACK and ERR is an error
        cur_vec = 101;
        issue(32'h0000_7100, 32'h0102_0304, 2'b00, 3'd5, 1'b0);
        BUS_ACK = 1'b1;
        BUS_ERR = 1'b1;
        #1;
        chk("ackerr_rdy", {31'd0, WR_RDY}, 32'd0);
        tick();
        BUS_ACK = 1'b0;
        BUS_ERR = 1'b0;
        #1;
        chk("ackerr_berr", {31'd0, WR_BERR}, 32'd1);
        chk("ackerr_busy", {31'd0, WR_BUSY}, 32'd0);
        tick();

        // Reset asserted during CYC2 clears everything at once
        cur_vec = 102;
        issue(32'h0000_1001, 32'hAABB_CCDD, 2'b00, 3'd1, 1'b1);
        BUS_ACK = 1'b1;
        tick();
        BUS_ACK = 1'b0;
        #1;
        chk("rst_in_c2_adr", BUS_ADR, 32'h0000_1004);
        RESET_n = 1'b0;
        #1;
        check_idle("rst_async");
        chk("rst_async_berr", {31'd0, WR_BERR}, 32'd0);
        #3 RESET_n = 1'b1;
        tick();
        #1;
        chk("rst_after_berr", {31'd0, WR_BERR}, 32'd0);
        chk("rst_after_busy", {31'd0, WR_BUSY}, 32'd0);
        cur_vec = 103;
        run_vec(vecs[0]);
        tick();

        // A request during CYC1 must not disturb the cycle in flight
        cur_vec = 104;
        issue(32'h0000_8000, 32'h0102_0304, 2'b00, 3'd5, 1'b0);
        WR_ADR  = 32'h0000_9001;
        WR_DATA = 32'hFFFF_FFFF;
        WR_REQ  = 1'b1;
        tick();
        WR_REQ  = 1'b0;
        #1;
        chk("ovl_adr",  BUS_ADR,  32'h0000_8000);
        chk("ovl_data", BUS_DATA, 32'h0102_0304);
        BUS_ACK = 1'b1;
        #1;
        chk("ovl_rdy", {31'd0, WR_RDY}, 32'd1);
        tick();
        BUS_ACK = 1'b0;
        #1;
        check_idle("ovl_idle");
        tick();
        #1;
        chk("ovl_stays_idle", {31'd0, WR_BUSY}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
